// File: rtl/mem_pkg.sv
// Shared encodings for the RV32I MEM stage: funct3 access sizes, writeback select, FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Size lives in funct3[1:0]; bit 2 only selects zero-extension for loads.
    function automatic logic is_misaligned(input logic [1:0] lsb, input logic [2:0] f3);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lsb[0];
            2'b10:   mis = (lsb != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane steering for stores, load extraction/extension and misalign detect.
module load_store_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
        logic signed [XLEN-1:0] r;
        r = b;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
        logic signed [XLEN-1:0] r;
        r = h;
        return r;
    endfunction

    // Only the bits that pick a lane are used, so misaligned low bits fall away here.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte   = 8'(load_word >> {addr[1:0], 3'b000});
        ld_half   = 16'(load_word >> {addr[1], 4'b0000});
        load_data = load_word;
        case (funct3)
            F3_B:    load_data = sext8(ld_byte);
            F3_H:    load_data = sext16(ld_half);
            F3_BU:   load_data = XLEN'(ld_byte);
            F3_HU:   load_data = XLEN'(ld_half);
            default: load_data = load_word;
        endcase
    end

    assign misalign = is_misaligned(addr[1:0], funct3);

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: req/gnt/rvalid data-memory access, MEM/WB register and hazard stall.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and are flagged.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_pc_incr,
    input  logic            in_load,
    input  logic            in_store,
    input  logic [2:0]      in_funct3,
    input  logic            in_reg_write,
    input  logic [1:0]      in_memtoreg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic [XLEN-1:0] fwd_mem_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_reg_write,
    output logic [1:0]      wb_memtoreg,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_load_data,
    output logic [XLEN-1:0] wb_pc_incr,
    output logic            wb_misalign
);

    mem_state_t      state, state_nxt;
    logic            is_mem, is_load, is_store, trap, go, capture;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata, load_ext;
    logic            misalign;

    load_store_align #(.XLEN(XLEN)) u_align (
        .addr       (in_alu_result),
        .funct3     (in_funct3),
        .store_data (in_rs2_data),
        .load_word  (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_ext),
        .misalign   (misalign)
    );

    // A simultaneous load+store is resolved as a load.
    assign is_mem   = in_valid && (in_load || in_store);
    assign is_load  = in_load;
    assign is_store = in_store && !in_load;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && misalign;
`else
    logic misalign_unused;
    assign misalign_unused = misalign;
    assign trap            = 1'b0;
`endif

    assign go = is_mem && !trap;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = dmem_gnt ? RESP : REQ;
            REQ:     if (dmem_gnt) state_nxt = RESP;
            RESP:    if (dmem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // capture marks the cycle in which the EX/MEM slot retires into MEM/WB.
    always_comb begin
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req  = go;
                mem_stall = go;
                capture   = !go;
            end
            REQ: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
            end
            RESP: begin
                mem_stall = !dmem_rvalid;
                capture   = dmem_rvalid;
            end
            default: ;
        endcase
    end

    assign dmem_we      = dmem_req && is_store;
    assign dmem_addr    = {in_alu_result[XLEN-1:2], 2'b00};
    assign dmem_wdata   = lane_wdata;
    assign dmem_be      = lane_be;
    assign fwd_mem_data = in_alu_result;

    // MEM/WB register: a stalled cycle retires a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd_addr    <= '0;
            wb_memtoreg   <= '0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
            wb_pc_incr    <= '0;
            wb_misalign   <= 1'b0;
        end else begin
            wb_valid      <= capture && in_valid;
            wb_reg_write  <= capture && in_valid && in_reg_write && !trap;
            wb_rd_addr    <= in_rd_addr;
            wb_memtoreg   <= in_memtoreg;
            wb_alu_result <= in_alu_result;
            wb_pc_incr    <= in_pc_incr;
            wb_load_data  <= (capture && in_valid && is_load && state == RESP) ? load_ext : '0;
            wb_misalign   <= capture && trap;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM/WB records, a monitor pops them.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_load, in_store, in_reg_write;
    logic [31:0] in_alu_result, in_rs2_data, in_pc_incr;
    logic [4:0]  in_rd_addr;
    logic [2:0]  in_funct3;
    logic [1:0]  in_memtoreg;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall;
    logic [31:0] fwd_mem_data;
    logic        wb_valid, wb_reg_write, wb_misalign;
    logic [4:0]  wb_rd_addr;
    logic [1:0]  wb_memtoreg;
    logic [31:0] wb_alu_result, wb_load_data, wb_pc_incr;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
        .in_rd_addr(in_rd_addr), .in_pc_incr(in_pc_incr), .in_load(in_load),
        .in_store(in_store), .in_funct3(in_funct3), .in_reg_write(in_reg_write),
        .in_memtoreg(in_memtoreg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .fwd_mem_data(fwd_mem_data),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .wb_memtoreg(wb_memtoreg), .wb_alu_result(wb_alu_result),
        .wb_load_data(wb_load_data), .wb_pc_incr(wb_pc_incr), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  memtoreg;
        logic [31:0] alu;
        logic [31:0] load_data;
        logic [31:0] pc_incr;
        logic        misalign;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_wb     = 0;
    int n_push   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every wb_valid pulse must match the oldest outstanding expectation.
    wb_exp_t e;
    always @(negedge clk) begin
        if (!rst && wb_valid === 1'b1) begin
            n_wb++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd_addr",    32'(wb_rd_addr),    32'(e.rd));
                chk("wb_reg_write",  32'(wb_reg_write),  32'(e.reg_write));
                chk("wb_memtoreg",   32'(wb_memtoreg),   32'(e.memtoreg));
                chk("wb_alu_result", wb_alu_result,      e.alu);
                chk("wb_load_data",  wb_load_data,       e.load_data);
                chk("wb_pc_incr",    wb_pc_incr,         e.pc_incr);
                chk("wb_misalign",   32'(wb_misalign),   32'(e.misalign));
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_reg_write = 1'b0;
        in_funct3 = 3'b000; in_memtoreg = 2'd0; in_rd_addr = 5'd0;
        in_alu_result = 32'd0; in_rs2_data = 32'd0; in_pc_incr = 32'd0;
    endtask

    // Issue one EX/MEM slot at posedge+1 and act as the memory until the slot retires.
    task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input int exp_req, input int exp_stall,
                          input logic [31:0] exp_ld, input logic exp_mis);
        wb_exp_t x;
        int req_cnt, stall_cnt, gnt_cyc;
        bit done;
        logic [31:0] waddr;
        waddr         = {addr[31:2], 2'b00};
        in_valid      = 1'b1;
        in_load       = ld;
        in_store      = st;
        in_funct3     = f3;
        in_alu_result = addr;
        in_rs2_data   = rs2;
        in_rd_addr    = rd;
        in_reg_write  = ld || !st;
        in_memtoreg   = ld ? WB_SEL_MEM : WB_SEL_ALU;
        in_pc_incr    = addr + 32'h1000;
        x.rd = rd; x.reg_write = (ld || !st) && !exp_mis; x.memtoreg = in_memtoreg;
        x.alu = addr; x.load_data = exp_ld; x.pc_incr = addr + 32'h1000; x.misalign = exp_mis;
        exp_q.push_back(x);
        n_push++;
        req_cnt = 0; stall_cnt = 0; gnt_cyc = -1; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c == 0) chk({tag, "_fwd"}, fwd_mem_data, addr);
            if (dmem_req) begin
                chk({tag, "_addr"}, dmem_addr, waddr);
                if (req_cnt == 0) begin
                    chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
                    chk({tag, "_we"}, 32'(dmem_we), 32'(st && !ld));
                    if (st && !ld) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
                end
                dmem_gnt = (req_cnt == gnt_dly);
                if (dmem_gnt) gnt_cyc = c;
                req_cnt++;
            end
            dmem_rvalid = (gnt_cyc >= 0) && (c == gnt_cyc + rv_dly);
            dmem_rdata  = dmem_rvalid ? rdata : 32'h0;
            #1;
            if (mem_stall) stall_cnt++;
            else           done = 1;
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid",     32'(wb_valid),     32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_alu",       wb_alu_result,     32'd0);
        chk("rst_dmem_req",     32'(dmem_req),     32'd0);
        chk("rst_mem_stall",    32'(mem_stall),    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("alu",  1'b0, 1'b0, F3_B,  32'h0000_1234, 32'h0,          5'd5, 0, 1, 32'h0,
               4'b0001, 32'h0,          0, 0, 32'h0,          1'b0);
        run_op("sb",   1'b0, 1'b1, F3_B,  32'h0000_0102, 32'hAABB_CCDD, 5'd6, 0, 1, 32'h0,
               4'b0100, 32'hDDDD_DDDD, 1, 1, 32'h0,          1'b0);
        run_op("lb",   1'b1, 1'b0, F3_B,  32'h0000_0203, 32'h0,          5'd7, 0, 1, 32'h80FF_FFFF,
               4'b1000, 32'h0,          1, 1, 32'hFFFF_FF80, 1'b0);
        run_op("lbu",  1'b1, 1'b0, F3_BU, 32'h0000_0203, 32'h0,          5'd8, 0, 1, 32'h80FF_FFFF,
               4'b1000, 32'h0,          1, 1, 32'h0000_0080, 1'b0);
        run_op("lh",   1'b1, 1'b0, F3_H,  32'h0000_0202, 32'h0,          5'd9, 0, 1, 32'h8001_1234,
               4'b1100, 32'h0,          1, 1, 32'hFFFF_8001, 1'b0);
        run_op("lhu",  1'b1, 1'b0, F3_HU, 32'h0000_0200, 32'h0,          5'd10, 0, 1, 32'h8001_F234,
               4'b0011, 32'h0,          1, 1, 32'h0000_F234, 1'b0);
        run_op("sh",   1'b0, 1'b1, F3_H,  32'h0000_0106, 32'h1122_3344, 5'd11, 0, 1, 32'h0,
               4'b1100, 32'h3344_3344, 1, 1, 32'h0,          1'b0);
        run_op("lw_slow", 1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0,        5'd12, 3, 2, 32'h1234_5678,
               4'b1111, 32'h0,          4, 5, 32'h1234_5678, 1'b0);
        run_op("sw",   1'b0, 1'b1, F3_W,  32'h0000_0310, 32'hCAFE_BABE, 5'd13, 1, 1, 32'h0,
               4'b1111, 32'hCAFE_BABE, 2, 2, 32'h0,          1'b0);
        run_op("ld_st", 1'b1, 1'b1, F3_W, 32'h0000_0320, 32'h5555_5555, 5'd14, 0, 1, 32'h0BAD_F00D,
               4'b1111, 32'h0,          1, 1, 32'h0BAD_F00D, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        run_op("lw_mis", 1'b1, 1'b0, F3_W, 32'h0000_0202, 32'h0,         5'd15, 0, 1, 32'h7777_7777,
               4'b1111, 32'h0,          0, 0, 32'h0,          1'b1);
`else
        run_op("lw_mis", 1'b1, 1'b0, F3_W, 32'h0000_0202, 32'h0,         5'd15, 0, 1, 32'h7777_7777,
               4'b1111, 32'h0,          1, 1, 32'h7777_7777, 1'b0);
`endif

        // Bubble with stray bus handshakes: nothing may retire or stall.
        in_load = 1'b1; in_reg_write = 1'b1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("bubble_req",   32'(dmem_req),  32'd0);
        chk("bubble_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        idle_inputs();
        chk("bubble_wb_valid",     32'(wb_valid),     32'd0);
        chk("bubble_wb_reg_write", 32'(wb_reg_write), 32'd0);

        // Reset while waiting in RESP; the late rvalid must be ignored.
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = F3_W; in_alu_result = 32'h0000_0400;
        in_rd_addr = 5'd9; in_reg_write = 1'b1; in_memtoreg = WB_SEL_MEM;
        #1;
        chk("rr_req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #1;
        chk("rr_resp_stall", 32'(mem_stall), 32'd1);
        chk("rr_resp_req",   32'(dmem_req),  32'd0);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rr_post_req",     32'(dmem_req),     32'd0);
        chk("rr_post_stall",   32'(mem_stall),    32'd0);
        chk("rr_post_wbvalid", 32'(wb_valid),     32'd0);
        chk("rr_post_wbrw",    32'(wb_reg_write), 32'd0);
        chk("rr_post_wbalu",   wb_alu_result,     32'd0);
        chk("rr_post_wbld",    wb_load_data,      32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        #1;
        chk("rr_late_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk("rr_late_wbvalid", 32'(wb_valid),     32'd0);
        chk("rr_late_wbld",    wb_load_data,      32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("wb_pulses",   32'(n_wb),         32'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline; consumes the EX/MEM register contents (ALU result, rs2 data, rd, load/store control).
- Performs data-memory access over a req/gnt/rvalid bus: store byte-lane generation, load extraction and sign/zero extension.
- Owns the MEM/WB pipeline register and raises a stall to the hazard unit while an access is in flight.
- Also supplies the MEM-stage forwarding value.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- in_alu_result  in  32  address, or result for non-memory ops
- in_rs2_data  in  32  store data
- in_rd_addr  in  5  destination register
- in_pc_incr  in  32  pc+4, for jal/jalr writeback
- in_load  in  1  instruction is a load
- in_store  in  1  instruction is a store
- in_funct3  in  3  access size/sign
- in_reg_write  in  1  writes rd
- in_memtoreg  in  2  writeback select: 0 ALU, 1 load, 2 pc+4
- dmem_req  out  1  request valid
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response (load data or store ack)
- dmem_rdata  in  32  raw load word
- mem_stall  out  1  freeze IF/ID/EX and hold EX/MEM
- fwd_mem_data  out  32  in_alu_result, combinational
- wb_valid, wb_rd_addr(5), wb_reg_write, wb_memtoreg(2), wb_alu_result(32), wb_load_data(32), wb_pc_incr(32)  out  MEM/WB register
- wb_misalign  out  1  registered misaligned-access flag

Behaviour:
- Reset: state IDLE; all wb_* outputs 0; dmem_req 0; mem_stall 0.
- Non-memory op (in_valid, neither load nor store): MEM/WB captures in 1 cycle; wb_load_data = 0; mem_stall stays 0.
- in_valid = 0: MEM/WB captures a bubble (wb_valid = 0; other wb_* fields are don't-care, but wb_reg_write = 0).
- FSM state IDLE: on a valid, aligned memory op, dmem_req = 1 combinationally and mem_stall = 1.
  - gnt in the same cycle -> RESP; otherwise -> REQ.
- FSM state REQ: dmem_req held at 1; address/data/be held stable (inputs are frozen by the stall); mem_stall = 1; gnt -> RESP.
- FSM state RESP: dmem_req = 0.
  - On rvalid: MEM/WB captures with wb_valid = 1; loads latch the extended data; mem_stall = 0 this cycle; -> IDLE.
  - Otherwise mem_stall = 1.
- Minimum memory-op latency: 2 cycles (1 stall cycle). While mem_stall = 1, MEM/WB captures a bubble.
- rvalid in IDLE or REQ: ignored. gnt outside a request: ignored.
- Store lanes: SB be = 1 << addr[1:0], wdata = byte replicated ×4; SH be = 0011 or 1100, wdata = half replicated ×2; SW be = 1111.
- Load extraction: LB/LBU take the byte at addr[1:0]; LH/LHU take the half at addr[1]; LW takes the whole word.
  - funct3 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW.
- dmem_addr = {addr[31:2], 2'b00}.
- Misaligned access: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0; see Optional Feature.
- Load and store both asserted: treated as a load.
- Reset mid-access: state -> IDLE, dmem_req drops at the next edge, a late rvalid is ignored, MEM/WB is cleared.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no bus request and causes no stall; MEM/WB captures in 1 cycle with wb_misalign = 1 and wb_reg_write forced to 0.
- Undefined: the address is treated as aligned (low bits ignored for the be/lane shift); the access proceeds normally; wb_misalign is tied to 0.

Decomposition:
- Shared package mem_pkg: funct3 load/store encodings, mem_state_t enum {IDLE, REQ, RESP}, memtoreg encodings.
- One sub-module, load_store_align: combinational be/wdata generation, load extension, misalign detect.

Test Plan:
- ALU op: rd = 5, alu_result = 0x1234 -> next cycle wb_valid = 1, wb_alu_result = 0x1234, mem_stall never 1.
- SB at addr 0x102, rs2 = 0xAABBCCDD, gnt immediate, rvalid next cycle -> dmem_be = 0100, wdata = 0xDDDDDDDD, dmem_addr = 0x100, exactly 1 stall cycle.
- LB at 0x203, rdata = 0x80FFFFFF -> wb_load_data = 0xFFFFFF80; same access as LBU -> 0x00000080.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> dmem_req held 4 cycles, addr stable throughout, mem_stall high until the rvalid cycle, exactly one wb_valid pulse.
- Reset asserted in RESP, rvalid arriving afterwards -> state IDLE, no wb_valid, all outputs 0.
- LW at 0x202 -> with MEM_MISALIGN_TRAP_EN: no dmem_req, wb_misalign = 1, wb_reg_write = 0; without it: dmem_addr = 0x200, normal 2-cycle access.
